seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector. Samples a qualified 1-bit stream and pulses `match_o` whenever the last `PAT_W` accepted bits equal a runtime-loadable pattern under a don't-care mask. Selectable overlapping or non-overlapping detection; saturating match counter. Sits between a serial input and the control logic that consumes detection events; supersedes the fixed 5-bit "10111" detector.

## Interface
- `PAT_W`, 5: pattern length in bits; legal range 2..32.
- `PAT_INIT`, 5'b10111: pattern after reset; `PAT_W` bits wide.
- `MASK_INIT`, all ones: compare mask after reset; bit = 1 compares, bit = 0 is don't-care.
- `CNT_W`, 8: match counter width; range 1..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data bit.
- `din_vld`  in  1  `din` is accepted on an edge where this is 1.
- `ovl_en`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `pat_load`  in  1  loads `pat_in`/`mask_in`; single-cycle strobe.
- `pat_in`  in  PAT_W  new pattern; MSB = first bit received.
- `mask_in`  in  PAT_W  new mask, same bit ordering.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `match_o`  out  1  one-cycle detection pulse, registered.
- `match_cnt`  out  CNT_W  saturating count of `match_o` pulses.
- `armed`  out  1  history holds `PAT_W` valid bits (fill == PAT_W).

## Operation
- State: history shift register `hist[PAT_W-1:0]`, fill counter `fill` (0..PAT_W, width clog2(PAT_W+1)), pattern reg, mask reg, hit flag `hit_q`, `match_o`, `match_cnt`.
- Accept (edge with `din_vld`=1 and `pat_load`=0): `hist` <= {hist[PAT_W-2:0], din}; `fill` <= min(fill+1, PAT_W).
- Hit: computed from the post-accept values: fill_next == PAT_W and (hist_next & mask) == (pat & mask). `hit_q` <= hit on that edge; `hit_q` <= 0 on any edge without an accept.
- Overlap: `ovl_en`=1: `fill` stays PAT_W after a hit, so a later match may reuse bits. `ovl_en`=0: on a hit `fill` <= 0 instead of PAT_W (`hist` still shifts), so the next match needs `PAT_W` fresh accepted bits.
- Load: `pat_load`=1 writes pattern and mask, forces `fill` <= 0 and `hit_q` <= 0; history is discarded. Load beats a simultaneous accept: that `din` bit is dropped.
- Counter: increments on the edge where `match_o` goes 1; holds at 2^CNT_W-1. `cnt_clr` beats a simultaneous increment: result is 0.
- `ovl_en` is read only on hit edges. Changing it mid-stream has no effect on `hist` or `fill`.
- Mask all zero: every accept with `fill` reaching PAT_W is a hit.

## Timing
- Reset (async assert, sync release): `hist`=0, `fill`=0, pattern=`PAT_INIT`, mask=`MASK_INIT`, `hit_q`=0, `match_o`=0, `match_cnt`=0, `armed`=0.
- Latency: final pattern bit accepted on edge k; `hit_q`=1 after edge k; `match_o`=1 after edge k+1, exactly one cycle. `match_cnt` updates on edge k+1.
- Back-to-back hits on consecutive accepts (overlap mode, e.g. all-ones pattern with all-ones input) give `match_o` high on consecutive cycles, one pulse per hit.
- `din_vld` gaps stretch the window; idle cycles never create or repeat a hit.
- `armed` is combinational from `fill`; it is valid in the cycle after the edge that updates `fill`.
- Reset mid-stream clears the partial match. A pending `hit_q`/`match_o` is dropped and not counted.

## Test plan
- Default pattern, `ovl_en`=1, bits 1,0,1,1,1,0,1,1,1 on consecutive cycles -> `match_o` pulses 2 edges after bit 5 and after bit 9; `match_cnt`=2.
- Same stream, `ovl_en`=0 -> single pulse after bit 5; after bit 9 no pulse and `armed`=0 (`fill`=4); one extra bit 1 gives no hit ("01111" ≠ "10111"), `match_cnt`=1.
- Load `pat_in`=5'b10111, `mask_in`=5'b11011, then stream 1,0,0,1,1 -> one pulse; stream 1,1,1,1,1 -> no pulse.
- `CNT_W`=2, pattern all ones, `ovl_en`=1, 9 consecutive ones -> 5 pulses, `match_cnt` saturates at 3. `cnt_clr` on the same edge as the 5th increment -> 0.
- Accept 1,0,1,1 then `pat_load` with `din_vld`=1, `din`=1 on the same edge -> bit dropped, `fill`=0, no pulse. Then 5 fresh bits of the new pattern -> one pulse.
- Accept 1,0,1,1, assert `rst_n`=0 mid-cycle -> all outputs 0 immediately. After release, bit 1 alone -> no pulse. Full 1,0,1,1,1 spread across `din_vld` gaps -> exactly one one-cycle pulse.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: masked serial pattern detector with overlap control and saturating match counter
module seq_detect_param #(
    parameter int PAT_W = 5,
    parameter logic [PAT_W-1:0] PAT_INIT = 5'b10111,
    parameter logic [PAT_W-1:0] MASK_INIT = {PAT_W{1'b1}},
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_vld,
    input  logic             ovl_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             cnt_clr,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    logic [PAT_W-1:0] hist, pat, mask, hist_nxt;
    logic [FW-1:0] fill, fill_inc;
    logic accept, hit, hit_q;
    assign accept   = din_vld & ~pat_load;
    assign hist_nxt = {hist[PAT_W-2:0], din};
    assign fill_inc = (fill == FULL) ? fill : fill + FW'(1);
    assign hit      = accept && (fill_inc == FULL) && (((hist_nxt ^ pat) & mask) == '0);
    assign armed    = fill == FULL;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist      <= '0;
            fill      <= '0;
            pat       <= PAT_INIT;
            mask      <= MASK_INIT;
            hit_q     <= 1'b0;
            match_o   <= 1'b0;
            match_cnt <= '0;
        end else begin
            match_o <= hit_q;
            if (cnt_clr)
                match_cnt <= '0;
            else if (hit_q && match_cnt != {CNT_W{1'b1}})
                match_cnt <= match_cnt + CNT_W'(1);
            if (pat_load) begin
                pat   <= pat_in;
                mask  <= mask_in;
                hist  <= '0;
                fill  <= '0;
                hit_q <= 1'b0;
            end else if (accept) begin
                hist  <= hist_nxt;
                fill  <= (hit && !ovl_en) ? '0 : fill_inc;
                hit_q <= hit;
            end else begin
                hit_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random checks of seq_detect_param against a queue-based window model
module tb_seq_detect_param;
    logic clk = 0, rst_n = 0, din = 0, din_vld = 0, ovl_en = 0, pat_load = 0, cnt_clr = 0;
    logic [4:0] pat_in = '0, mask_in = '0;
    logic match_o, armed;
    logic [7:0] match_cnt;
    int checks = 0, failures = 0;
    bit q[$];
    logic [4:0] m_pat, m_mask;
    bit m_hq, m_mo;
    int m_cnt;

    seq_detect_param dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .ovl_en(ovl_en),
        .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in), .cnt_clr(cnt_clr),
        .match_o(match_o), .match_cnt(match_cnt), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_pat = 5'b10111;
        m_mask = 5'b11111;
        m_hq = 0;
        m_mo = 0;
        m_cnt = 0;
    endtask

    // window model: queue of accepted bits since last reset/load/non-overlap hit, oldest first
    task automatic step(bit v, bit d, bit o, bit ld = 0, logic [4:0] p = 0, logic [4:0] mk = 0, bit clr = 0);
        bit hit;
        @(negedge clk);
        din_vld = v; din = d; ovl_en = o; pat_load = ld; pat_in = p; mask_in = mk; cnt_clr = clr;
        @(posedge clk);
        hit = 0;
        if (clr) m_cnt = 0;
        else if (m_hq && m_cnt < 255) m_cnt++;
        m_mo = m_hq;
        if (ld) begin
            m_pat = p; m_mask = mk; q.delete(); m_hq = 0;
        end else if (v) begin
            q.push_back(d);
            if (q.size() > 5) void'(q.pop_front());
            if (q.size() == 5) begin
                hit = 1;
                for (int i = 0; i < 5; i++)
                    if (m_mask[4-i] && q[i] != m_pat[4-i]) hit = 0;
            end
            m_hq = hit;
            if (hit && !o) q.delete();
        end else m_hq = 0;
        #1;
        chk("match_o", match_o, m_mo);
        chk("match_cnt", match_cnt, m_cnt);
        chk("armed", armed, q.size() == 5);
    endtask

    task automatic feed(logic [15:0] bits, int n, bit o);
        for (int i = n - 1; i >= 0; i--) step(1, bits[i], o);
    endtask

    task automatic idle(int n, bit o);
        for (int i = 0; i < n; i++) step(0, 0, o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; din_vld = 0; pat_load = 0; cnt_clr = 0;
        m_reset();
        #1;
        chk("rst_match_o", match_o, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_armed", armed, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        m_reset();
        do_reset();
        // overlapping default pattern
        feed(16'b101110111, 9, 1);
        idle(2, 1);
        chk("ovl_cnt", match_cnt, 2);
        // non-overlapping
        do_reset();
        feed(16'b101110111, 9, 0);
        chk("novl_armed", armed, 0);
        feed(16'b1, 1, 0);
        idle(2, 0);
        chk("novl_cnt", match_cnt, 1);
        // masked pattern
        do_reset();
        step(0, 0, 0, 1, 5'b10111, 5'b11011);
        feed(16'b10011, 5, 0);
        feed(16'b11111, 5, 0);
        idle(2, 0);
        chk("mask_cnt", match_cnt, 1);
        // all-zero mask: every full window hits
        do_reset();
        step(0, 0, 1, 1, 5'b01010, 5'b00000);
        feed(16'b1100101, 7, 1);
        idle(2, 1);
        chk("mask0_cnt", match_cnt, 3);
        // saturation and clear priority
        do_reset();
        step(0, 0, 1, 1, 5'b11111, 5'b11111);
        for (int i = 0; i < 262; i++) step(1, 1, 1);
        idle(2, 1);
        chk("sat_cnt", match_cnt, 255);
        step(0, 0, 1, 0, 0, 0, 1);
        step(1, 1, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        chk("clr_prio", match_cnt, 0);
        idle(2, 1);
        // load beats accept
        do_reset();
        feed(16'b1011, 4, 1);
        step(1, 1, 1, 1, 5'b01101, 5'b11111);
        chk("load_armed", armed, 0);
        feed(16'b01101, 5, 1);
        idle(2, 1);
        chk("load_cnt", match_cnt, 1);
        // reset mid-stream with a pulse outstanding
        do_reset();
        feed(16'b10111, 5, 1);
        step(0, 0, 1);
        chk("pre_rst_pulse", match_o, 1);
        do_reset();
        feed(16'b1, 1, 1);
        idle(2, 1);
        step(1, 1, 1); idle(1, 1);
        step(1, 0, 1); idle(2, 1);
        step(1, 1, 1); step(1, 1, 1); idle(1, 1);
        step(1, 1, 1);
        idle(3, 1);
        chk("gap_cnt", match_cnt, 1);
        // random traffic
        do_reset();
        begin
            bit o;
            o = 1;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 49) == 0) o = ~o;
                step($urandom_range(0, 9) < 7, 1'($urandom), o, $urandom_range(0, 99) == 0,
                     5'($urandom), 5'($urandom) | 5'($urandom), $urandom_range(0, 199) == 0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
